// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: angle writes become saturated pulse widths that take effect only at frame boundaries.
// Define SERVO_SLEW_EN to rate-limit each channel's width change to SLEW_STEP per frame.

module servo_pwm_multi #(
  parameter int unsigned CH        = 4,
  parameter int unsigned PERIOD    = 2_000_000,
  parameter int unsigned PULSE_MIN = 50_000,
  parameter int unsigned PULSE_MAX = 250_000,
  parameter int unsigned PULSE_MID = 150_000,
  parameter int unsigned STEP      = 741,
  parameter int unsigned ANGLE_MAX = 270,
  parameter int unsigned SLEW_STEP = 5_000
) (
  input  logic          sclk,
  input  logic          rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [3:0]    wr_ch,
  input  logic [8:0]    wr_angle,
  output logic          wr_err,
  output logic          frame_start,
  output logic [CH-1:0] pwm
);

  localparam int unsigned RAW_MAX = PULSE_MIN + ANGLE_MAX * STEP;
  localparam int unsigned CAP     = (PULSE_MAX < PERIOD - 1) ? PULSE_MAX : PERIOD - 1;
  localparam int unsigned BIG_A   = (RAW_MAX > PERIOD - 1) ? RAW_MAX : PERIOD - 1;
  localparam int unsigned BIG     = (BIG_A > PULSE_MID) ? BIG_A : PULSE_MID;
  localparam int          WW      = $clog2(BIG + 1);
  localparam int          CHW     = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [WW-1:0] LAST   = WW'(PERIOD - 1);
  localparam logic [WW-1:0] MID_W  = WW'(PULSE_MID);
  localparam logic [WW-1:0] MIN_W  = WW'(PULSE_MIN);
  localparam logic [WW-1:0] STEP_W = WW'(STEP);
  localparam logic [WW-1:0] CAP_W  = WW'(CAP);
`ifdef SERVO_SLEW_EN
  localparam logic [WW-1:0] SLEW_W = WW'(SLEW_STEP);
`endif

  // Catch impossible configurations at elaboration rather than in silicon.
  if (CH < 1 || CH > 16 || PULSE_MIN > PULSE_MAX || SLEW_STEP == 0) begin : g_bad_params
    $error("servo_pwm_multi: invalid parameter set");
  end

  logic [WW-1:0]  cnt_q, cnt_d;
  logic           rdy_q, err_q, fs_q;
  logic [CH-1:0]  pwm_q, pwm_d;
  logic           s1_vld_q;
  logic [CHW-1:0] s1_ch_q;
  logic [WW-1:0]  s1_width_q, s1_width_d;
  logic [WW-1:0]  target_q [CH];
  logic [WW-1:0]  target_d [CH];
  logic [WW-1:0]  active_q [CH];
  logic [WW-1:0]  active_d [CH];
  logic           accept, bad, boundary;
  logic [WW-1:0]  sat_width;

  always_comb begin
    accept     = wr_valid && rdy_q;
    bad        = (32'(wr_angle) > ANGLE_MAX) || (32'(wr_ch) >= CH);
    boundary   = (cnt_q == LAST);
    cnt_d      = boundary ? '0 : cnt_q + 1'b1;
    // Widened so the unsaturated sum of any legal angle cannot wrap.
    s1_width_d = MIN_W + WW'(wr_angle) * STEP_W;
    sat_width  = (s1_width_q > CAP_W) ? CAP_W : s1_width_q;
    pwm_d      = '0;
    for (int i = 0; i < int'(CH); i++) begin
      pwm_d[i]    = cnt_q < active_q[i];
      target_d[i] = target_q[i];
      active_d[i] = active_q[i];
      if (s1_vld_q && s1_ch_q == CHW'(i)) begin
        target_d[i] = sat_width;
      end
      // The load sees target_q, so a same-edge write waits one more frame.
      if (boundary) begin
`ifdef SERVO_SLEW_EN
        if (target_q[i] > active_q[i]) begin
          active_d[i] = (target_q[i] - active_q[i] > SLEW_W) ? active_q[i] + SLEW_W : target_q[i];
        end else begin
          active_d[i] = (active_q[i] - target_q[i] > SLEW_W) ? active_q[i] - SLEW_W : target_q[i];
        end
`else
        active_d[i] = target_q[i];
`endif
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      fs_q       <= 1'b0;
      pwm_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_width_q <= '0;
      for (int i = 0; i < int'(CH); i++) begin
        target_q[i] <= MID_W;
        active_q[i] <= MID_W;
      end
    end else begin
      cnt_q      <= cnt_d;
      rdy_q      <= !accept;
      err_q      <= accept && bad;
      fs_q       <= (cnt_q == '0);
      pwm_q      <= pwm_d;
      s1_vld_q   <= accept && !bad;
      s1_ch_q    <= wr_ch[CHW-1:0];
      s1_width_q <= s1_width_d;
      for (int i = 0; i < int'(CH); i++) begin
        target_q[i] <= target_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  assign wr_ready    = rdy_q;
  assign wr_err      = err_q;
  assign frame_start = fs_q;
  assign pwm         = pwm_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: frame-arithmetic reference model checked every cycle,
// plus measured pulse widths compared against hand-computed literals.

module tb_servo_pwm_multi;

  localparam int CH        = 4;
  localparam int P         = 1000;
  localparam int PULSE_MIN = 100;
  localparam int PULSE_MAX = 600;
  localparam int PULSE_MID = 300;
  localparam int STEP      = 2;
  localparam int ANGLE_MAX = 270;
  localparam int SLEW_STEP = 25;
`ifdef SERVO_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [3:0]    wr_ch = '0;
  logic [8:0]    wr_angle = '0;
  logic          wr_err;
  logic          frame_start;
  logic [CH-1:0] pwm;

  servo_pwm_multi #(
    .CH(CH), .PERIOD(P), .PULSE_MIN(PULSE_MIN), .PULSE_MAX(PULSE_MAX),
    .PULSE_MID(PULSE_MID), .STEP(STEP), .ANGLE_MAX(ANGLE_MAX), .SLEW_STEP(SLEW_STEP)
  ) dut (
    .sclk(sclk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_angle(wr_angle), .wr_err(wr_err),
    .frame_start(frame_start), .pwm(pwm)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: k = rising edges seen with rst_n high since reset.
  // In the cycle after edge k the frame position is (k-1) mod P.
  int        k = 0;
  int        m_tgt[CH];
  int        m_act[CH];
  bit        m_pend = 1'b0;
  int        m_pch = 0;
  int        m_pw = 0;
  bit        m_rdy = 1'b0;
  bit        m_armed = 1'b0;
  logic [CH-1:0] e_pwm = '0;
  logic      e_fs = 1'b0;
  logic      e_rdy = 1'b0;
  logic      e_err = 1'b0;

  function automatic int width_of(input int ang);
    int w;
    w = PULSE_MIN + ang * STEP;
    if (w > PULSE_MAX) w = PULSE_MAX;
    if (w > P - 1) w = P - 1;
    return w;
  endfunction

  function automatic int frame_width(input int cur, input int tgt);
    if (!SLEW) return tgt;
    if (tgt > cur) return (tgt - cur > SLEW_STEP) ? cur + SLEW_STEP : tgt;
    return (cur - tgt > SLEW_STEP) ? cur - SLEW_STEP : tgt;
  endfunction

  always @(posedge sclk) begin
    if (!rst_n) begin
      k = 0;
      for (int i = 0; i < CH; i++) begin
        m_tgt[i] = PULSE_MID;
        m_act[i] = PULSE_MID;
      end
      m_pend = 1'b0;
      m_rdy  = 1'b0;
      e_pwm  = '0;
      e_fs   = 1'b0;
      e_rdy  = 1'b0;
      e_err  = 1'b0;
      m_armed = 1'b1;
    end else begin
      bit acc;
      int ph;
      k++;
      ph = (k - 1) % P;
      e_fs = (ph == 0);
      for (int i = 0; i < CH; i++) e_pwm[i] = (ph < m_act[i]);
      if (k % P == 0) begin
        for (int i = 0; i < CH; i++) m_act[i] = frame_width(m_act[i], m_tgt[i]);
      end
      if (m_pend) begin
        m_tgt[m_pch] = m_pw;
        m_pend = 1'b0;
      end
      acc   = wr_valid && m_rdy;
      e_err = acc && (int'(wr_angle) > ANGLE_MAX || int'(wr_ch) >= CH);
      if (acc && !e_err) begin
        m_pend = 1'b1;
        m_pch  = int'(wr_ch);
        m_pw   = width_of(int'(wr_angle));
      end
      m_rdy = !acc;
      e_rdy = m_rdy;
    end
  end

  always @(negedge sclk) begin
    if (m_armed) begin
      checks++;
      if ({pwm, frame_start, wr_ready, wr_err} !== {e_pwm, e_fs, e_rdy, e_err}) begin
        errors++;
        $display("FAIL cycle_model t=%0t: got pwm=%b fs=%b rdy=%b err=%b, want pwm=%b fs=%b rdy=%b err=%b",
                 $time, pwm, frame_start, wr_ready, wr_err, e_pwm, e_fs, e_rdy, e_err);
      end
    end
  end

  // Pulse-width measurement: high cycles per channel, latched at each frame_start.
  int hi[CH];
  int meas[CH];
  int frm = 0;
  int cyc = 0;
  int last_fs = 0;
  int period_meas = 0;
  int err_pulses = 0;

  always @(negedge sclk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) hi[i] = 0;
    end else begin
      if (frame_start === 1'b1) begin
        for (int i = 0; i < CH; i++) begin
          meas[i] = hi[i];
          hi[i] = 0;
        end
        period_meas = cyc - last_fs;
        last_fs = cyc;
        frm++;
      end
      for (int i = 0; i < CH; i++) if (pwm[i] === 1'b1) hi[i]++;
      if (wr_err === 1'b1) err_pulses++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic wait_frames(input int n);
    int target;
    int budget;
    target = frm + n;
    budget = 0;
    while (frm < target && budget < n * P + 50) begin
      step(1);
      budget++;
    end
    if (frm < target) chk("frame_start_timeout", frm, target);
  endtask

  task automatic do_write(input int ch, input int ang, output int waited);
    waited   = 0;
    wr_valid = 1'b1;
    wr_ch    = 4'(ch);
    wr_angle = 9'(ang);
    while (wr_ready !== 1'b1 && waited < 20) begin
      step(1);
      waited++;
    end
    if (waited >= 20) chk("wr_ready_timeout", waited, 0);
    step(1);
    wr_valid = 1'b0;
  endtask

  initial begin
    int w1;
    int w2;
    int e0;
    int budget;

    rst_n = 1'b0;
    step(3);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_wr_ready", int'(wr_ready), 0);
    chk("reset_frame_start", int'(frame_start), 0);
    chk("reset_wr_err", int'(wr_err), 0);
    rst_n = 1'b1;
    step(1);
    chk("ready_after_reset", int'(wr_ready), 1);

    // Two idle frames at the reset width.
    wait_frames(2);
    for (int i = 0; i < CH; i++) chk($sformatf("frame0_width_ch%0d", i), meas[i], 300);
    wait_frames(1);
    for (int i = 0; i < CH; i++) chk($sformatf("frame1_width_ch%0d", i), meas[i], 300);
    chk("frame_period", period_meas, P);

    // Mid-frame write: current frame keeps its width.
    step(500);
    do_write(1, 0, w1);
    wait_frames(1);
    chk("ch1_same_frame", meas[1], 300);
    wait_frames(1);
    chk("ch1_next_frame", meas[1], SLEW ? 275 : 100);
    chk("ch0_untouched", meas[0], 300);

    // Saturation and rejected writes.
    step(100);
    e0 = err_pulses;
    do_write(2, 270, w1);
    do_write(0, 271, w1);
    do_write(5, 10, w1);
    step(3);
    chk("err_pulse_count", err_pulses - e0, 2);
    wait_frames(1);
    chk("ch2_same_frame", meas[2], 300);
    wait_frames(1);
    chk("ch2_saturated", meas[2], SLEW ? 325 : 600);
    chk("ch0_after_bad_writes", meas[0], 300);
    chk("ch1_settled", meas[1], SLEW ? 225 : 100);

    // Target lands on the boundary-load edge: takes effect one frame later.
    budget = 0;
    while (k % P != P - 2 && budget < P + 5) begin
      step(1);
      budget++;
    end
    do_write(3, 50, w1);
    wait_frames(1);
    chk("ch3_before", meas[3], 300);
    wait_frames(1);
    chk("ch3_boundary_frame_old", meas[3], 300);
    wait_frames(1);
    chk("ch3_following_frame_new", meas[3], SLEW ? 275 : 200);

    // Back-to-back writes: second one is held off for a cycle.
    step(50);
    do_write(0, 90, w1);
    do_write(1, 90, w2);
    chk("first_write_wait", w1, 0);
    chk("second_write_wait", w2, 1);

    // Reset mid-pulse with a write in flight.
    wait_frames(1);
    step(10);
    do_write(2, 0, w1);
    rst_n = 1'b0;
    step(1);
    chk("midreset_pwm_low", int'(pwm), 0);
    chk("midreset_ready_low", int'(wr_ready), 0);
    step(2);
    rst_n = 1'b1;
    wait_frames(2);
    for (int i = 0; i < CH; i++) chk($sformatf("post_reset_width_ch%0d", i), meas[i], 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/servo_pwm_multi.md
SERVO_PWM_MULTI -- requirements
Module: servo_pwm_multi

Interface
REQ-001 SHALL have parameter CH, default 4, number of independent servo channels (1..16).
REQ-002 SHALL have parameter PERIOD, default 2_000_000, frame length in sclk cycles (20 ms at 100 MHz).
REQ-003 SHALL have parameter PULSE_MIN, default 50_000, pulse width in cycles at angle 0.
REQ-004 SHALL have parameter PULSE_MAX, default 250_000, pulse width ceiling in cycles.
REQ-005 SHALL have parameter PULSE_MID, default 150_000, pulse width loaded at reset.
REQ-006 SHALL have parameter STEP, default 741, cycles per degree.
REQ-007 SHALL have parameter ANGLE_MAX, default 270, largest legal angle.
REQ-008 SHALL have parameter SLEW_STEP, default 5_000, maximum width change per frame (slew builds only).
REQ-009 sclk  input  1  system clock; all logic on its rising edge.
REQ-010 rst_n  input  1  reset, synchronous, active-low.
REQ-011 wr_valid  input  1  angle write request.
REQ-012 wr_ready  output  1  write accepted when wr_valid and wr_ready both high.
REQ-013 wr_ch  input  4  target channel index.
REQ-014 wr_angle  input  9  angle in degrees, unsigned.
REQ-015 wr_err  output  1  one-cycle pulse, write rejected.
REQ-016 frame_start  output  1  one-cycle pulse at start of each frame.
REQ-017 pwm  output  CH  servo outputs, bit i = channel i.

Function
REQ-018 Frame counter SHALL count 0..PERIOD-1 and wrap to 0; frame_start SHALL be high in the cycle after the counter equals 0.
REQ-019 Each channel SHALL hold a target width register and an active width register.
REQ-020 pwm[i] SHALL be registered and high for exactly active[i] consecutive cycles per frame, rising one cycle after the counter equals 0, coincident with frame_start.
REQ-021 Accepted write SHALL compute width = PULSE_MIN + wr_angle*STEP, saturated to PULSE_MAX, in a two-stage pipeline; target[wr_ch] updates 2 cycles after acceptance.
REQ-022 wr_ready SHALL go low the cycle after an acceptance and return high in the cycle target updates; back-to-back writes accept at most every 2 cycles.
REQ-023 Write with wr_angle > ANGLE_MAX or wr_ch >= CH SHALL be accepted but discarded, with wr_err high for exactly 1 cycle, 1 cycle after acceptance; no target changes.
REQ-024 When the counter equals PERIOD-1, every active[i] SHALL load from target[i] (no-slew) so widths change only at frame boundaries and never glitch mid-pulse.
REQ-025 Target update in the same cycle as the boundary load SHALL not be seen by that load; it takes effect at the following frame.
REQ-026 active[i] = 0 SHALL give no pulse; widths SHALL never exceed PERIOD-1.
REQ-027 Multiplication and addition SHALL use widths sufficient for ANGLE_MAX*STEP+PULSE_MIN without overflow before saturation.

Reset
REQ-028 While rst_n is low at a clock edge: counter = 0, all target and active = PULSE_MID, pipeline emptied, pwm = 0, wr_ready = 0, wr_err = 0, frame_start = 0.
REQ-029 wr_ready SHALL go high the first cycle after rst_n is sampled high; reset mid-write SHALL discard the in-flight write.

Configuration
REQ-030 With macro SERVO_SLEW_EN defined, the boundary load SHALL move active[i] toward target[i] by at most SLEW_STEP per frame, landing exactly on target.
REQ-031 Without SERVO_SLEW_EN, the boundary load SHALL copy target[i] directly and SLEW_STEP SHALL be unused.

Verification
REQ-032 Reset then run 2 frames -> every pwm bit high 150_000 cycles per 2_000_000-cycle frame; frame_start once per frame.
REQ-033 Write ch1 angle 0 mid-frame -> pwm[1] unchanged this frame, 50_000 cycles from next frame; other channels still 150_000.
REQ-034 Write ch2 angle 270 -> pwm[2] width saturates at 250_000 (not 250_070); write ch0 angle 271 or ch 5 -> wr_err 1-cycle pulse, no change.
REQ-035 Write ch3 so target updates at counter PERIOD-1 -> old width kept for next frame, new width the frame after; two writes on consecutive cycles -> second held off by wr_ready low.
REQ-036 SERVO_SLEW_EN defined, ch0 angle 0 from reset -> widths 145_000, 140_000, ... reaching 50_000 after 20 frames; without macro -> 50_000 on first frame.
REQ-037 Assert rst_n low mid-pulse and mid-write -> pwm low next cycle, all widths back to 150_000, in-flight write lost.
